// File: rtl/serial_readout_ctrl.sv
// Serial readout controller: fetches NWORDS memory words into a frame buffer and
// streams them MSB first. Optional trailing even-parity bit via SERIAL_PARITY_EN.
module serial_readout_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int NWORDS = 3,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              read_external,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              mem_rd_en,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for a qualified rising edge of read_external
  // FETCH | one read strobe per word, sources 0..NWORDS-1
  // WAIT  | draining the memory latency until the last word lands
  // SHIFT | streaming the frame buffer out MSB first
  // DONE  | one-cycle completion pulse

  localparam int FRAME_BITS = NWORDS * DATA_W;
`ifdef SERIAL_PARITY_EN
  localparam int TOTAL_BITS = FRAME_BITS + 1;
`else
  localparam int TOTAL_BITS = FRAME_BITS;
`endif
  localparam int CNT_W = $clog2(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TOTAL_BITS - 1);
  localparam logic [1:0] LAST_SEL = 2'(NWORDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    ext_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [1:0]              fetch_q;
  logic [RD_LAT-1:0]       pipe_vld;
  logic [1:0]              pipe_sel [RD_LAT];
  logic [FRAME_BITS-1:0]   frame_q;
  logic [CNT_W-1:0]        bit_cnt_q;
`ifdef SERIAL_PARITY_EN
  logic                    par_q;
`endif

  logic start, cap_vld, last_cap, last_fetch;
  logic [1:0] cap_sel;

  assign start      = read_external & ~ext_q & trigger;
  assign cap_vld    = pipe_vld[RD_LAT-1];
  assign cap_sel    = pipe_sel[RD_LAT-1];
  assign last_cap   = cap_vld && (cap_sel == LAST_SEL);
  assign last_fetch = (fetch_q == LAST_SEL);
  assign mem_sel    = fetch_q;
  assign mem_addr   = addr_q;

  always_comb begin
    state_d      = state_q;
    mem_rd_en    = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        if (last_fetch) state_d = WAIT;
      end
      WAIT: begin
        if (last_cap) state_d = SHIFT;
      end
      SHIFT: begin
        serial_valid = 1'b1;
`ifdef SERIAL_PARITY_EN
        serial_out = (bit_cnt_q == '0) ? par_q : frame_q[FRAME_BITS-1];
`else
        serial_out = frame_q[FRAME_BITS-1];
`endif
        if (bit_cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ext_q     <= 1'b1;  // a request held high through reset must not start a frame
      addr_q    <= '0;
      fetch_q   <= '0;
      pipe_vld  <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_sel[i] <= '0;
      frame_q   <= '0;
      bit_cnt_q <= '0;
`ifdef SERIAL_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ext_q   <= read_external;

      if (state_q == IDLE && start) addr_q <= read_addr;

      if (state_q == FETCH) fetch_q <= last_fetch ? 2'd0 : fetch_q + 2'd1;

      pipe_vld[0] <= mem_rd_en;
      pipe_sel[0] <= fetch_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_sel[i] <= pipe_sel[i-1];
      end

      // word 0 occupies the MSBs so it leaves the shifter first
      if (cap_vld) begin
        for (int w = 0; w < NWORDS; w++)
          if (int'(cap_sel) == w) frame_q[(NWORDS-1-w)*DATA_W +: DATA_W] <= mem_rdata;
      end else if (state_q == SHIFT) begin
        frame_q <= frame_q << 1;
      end

      if (state_q == WAIT && last_cap)
        bit_cnt_q <= CNT_LOAD;
      else if (state_q == SHIFT && bit_cnt_q != '0)
        bit_cnt_q <= bit_cnt_q - CNT_W'(1);

`ifdef SERIAL_PARITY_EN
      if (state_q == IDLE)
        par_q <= 1'b0;
      else if (state_q == SHIFT && bit_cnt_q != '0)
        par_q <= par_q ^ frame_q[FRAME_BITS-1];
`endif
    end
  end

endmodule

// File: tb/tb_serial_readout_ctrl.sv
// Directed bench for serial_readout_ctrl: default instance plus an RD_LAT=3 instance.
module tb_serial_readout_ctrl;

`ifdef SERIAL_PARITY_EN
  localparam int NB = 49;
`else
  localparam int NB = 48;
`endif

  logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, read_external = 1'b0, ext3 = 1'b0;
  logic [10:0] read_addr = 11'd0;
  logic [15:0] words [4];

  logic        rd_en, so, sv, busy, done;
  logic [1:0]  sel;
  logic [10:0] addr;
  logic [15:0] rdata = 16'hFFFF;
  logic        rd_en3, so3, sv3, busy3, done3;
  logic [1:0]  sel3;
  logic [10:0] addr3;
  logic [15:0] rdata3 = 16'hFFFF, m3_d1 = 16'hFFFF, m3_d2 = 16'hFFFF;

  int vectors = 0, miscompares = 0;
  int cyc = 0;

  serial_readout_ctrl dut (
    .clk(clk), .rst(rst), .trigger(trigger), .read_external(read_external),
    .read_addr(read_addr), .mem_rd_en(rd_en), .mem_sel(sel), .mem_addr(addr),
    .mem_rdata(rdata), .serial_out(so), .serial_valid(sv), .busy(busy), .done(done));

  serial_readout_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .trigger(trigger), .read_external(ext3),
    .read_addr(read_addr), .mem_rd_en(rd_en3), .mem_sel(sel3), .mem_addr(addr3),
    .mem_rdata(rdata3), .serial_out(so3), .serial_valid(sv3), .busy(busy3), .done(done3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory models: data valid exactly RD_LAT cycles after the strobe, 0xFFFF otherwise
  always @(posedge clk) rdata <= rd_en ? words[sel] : 16'hFFFF;
  always @(posedge clk) begin
    m3_d1  <= rd_en3 ? words[sel3] : 16'hFFFF;
    m3_d2  <= m3_d1;
    rdata3 <= m3_d2;
  end

  logic [63:0] rx = '0, rx3 = '0;
  logic [10:0] exp_addr = 11'd5;
  logic sv_q = 1'b0, sv3_q = 1'b0;
  int nbits = 0, rise_cyc = 0, nrise = 0, ndone = 0, nstrobe = 0, addr_err = 0, so_viol = 0, nbusy = 0;
  int nbits3 = 0, rise3_cyc = 0, ndone3 = 0, addr_err3 = 0;

  always @(negedge clk) begin
    if (sv) begin
      rx    <= {rx[62:0], so};
      nbits <= nbits + 1;
      if (!sv_q) begin
        nrise    <= nrise + 1;
        rise_cyc <= cyc;
      end
    end
    sv_q <= sv;
    if (!sv && so) so_viol <= so_viol + 1;
    if (done) ndone <= ndone + 1;
    if (busy) nbusy <= nbusy + 1;
    if (rd_en) begin
      nstrobe <= nstrobe + 1;
      if (addr != exp_addr) addr_err <= addr_err + 1;
    end
    if (sv3) begin
      rx3    <= {rx3[62:0], so3};
      nbits3 <= nbits3 + 1;
      if (!sv3_q) rise3_cyc <= cyc;
    end
    sv3_q <= sv3;
    if (done3) ndone3 <= ndone3 + 1;
    if (rd_en3 && addr3 != exp_addr) addr_err3 <= addr_err3 + 1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (ndone > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic set_words(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = 16'hFFFF;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    vectors++;
    if ({rd_en, so, sv, busy, done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 00000", {rd_en, so, sv, busy, done});
    end
    vectors++;
    if ({rd_en3, so3, sv3, busy3, done3} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs_lat3 got %b want 00000", {rd_en3, so3, sv3, busy3, done3});
    end
    vectors++;
    if ({sel, addr} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_sel_addr got %h want 0", {sel, addr});
    end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_frame_content;
    int b_bits, b_done, b_str, b_aerr, edge_c;
    bit ok;
    logic [47:0] exp_data, got;
    exp_data = 48'h1771_17A4_0019;
    set_words(16'h1771, 16'h17A4, 16'h0019);
    trigger = 1'b1; read_addr = 11'd5; exp_addr = 11'd5;
    read_external = 1'b0;
    tick(2);
    b_bits = nbits; b_done = ndone; b_str = nstrobe; b_aerr = addr_err;
    @(negedge clk);
    read_external = 1'b1;
    edge_c = cyc + 1;
    wait_done(b_done, 200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL frame1_timeout done=%0d want 1", ndone - b_done); end
    tick(2);
    got = rx[NB-1 -: 48];
    vectors++;
    if (got !== exp_data) begin miscompares++; $display("FAIL frame1_data got %h want %h", got, exp_data); end
    vectors++;
    if (nbits - b_bits !== NB) begin miscompares++; $display("FAIL frame1_bits got %0d want %0d", nbits - b_bits, NB); end
    vectors++;
    if (rise_cyc - edge_c !== 4) begin miscompares++; $display("FAIL frame1_latency got %0d want 4", rise_cyc - edge_c); end
    vectors++;
    if (ndone - b_done !== 1) begin miscompares++; $display("FAIL frame1_done got %0d want 1", ndone - b_done); end
    vectors++;
    if (nstrobe - b_str !== 3) begin miscompares++; $display("FAIL frame1_strobes got %0d want 3", nstrobe - b_str); end
    vectors++;
    if (addr_err - b_aerr !== 0) begin miscompares++; $display("FAIL frame1_addr got %0d bad strobes want 0", addr_err - b_aerr); end
    vectors++;
    if (so_viol !== 0) begin miscompares++; $display("FAIL idle_serial_out got %0d nonzero cycles want 0", so_viol); end
`ifdef SERIAL_PARITY_EN
    vectors++;
    if (rx[0] !== ^exp_data) begin miscompares++; $display("FAIL frame1_parity got %b want %b", rx[0], ^exp_data); end
`endif
  endtask

  task automatic test_second_frame;
    int b_bits, b_done, b_str, b_aerr;
    bit ok;
    logic [47:0] got;
    set_words(16'h0BBB, 16'h178B, 16'h1DD5);
    read_addr = 11'd5; exp_addr = 11'd5;
    read_external = 1'b0;
    tick(2);
    b_bits = nbits; b_done = ndone; b_str = nstrobe; b_aerr = addr_err;
    @(negedge clk);
    read_external = 1'b1;
    @(negedge clk);
    read_addr = 11'd9;  // address must already be latched
    wait_done(b_done, 200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL frame2_timeout done=%0d want 1", ndone - b_done); end
    tick(2);
    got = rx[NB-1 -: 48];
    vectors++;
    if (got !== 48'h0BBB_178B_1DD5) begin miscompares++; $display("FAIL frame2_data got %h want 0bbb178b1dd5", got); end
    vectors++;
    if (nbits - b_bits !== NB) begin miscompares++; $display("FAIL frame2_bits got %0d want %0d", nbits - b_bits, NB); end
    vectors++;
    if (nstrobe - b_str !== 3) begin miscompares++; $display("FAIL frame2_strobes got %0d want 3", nstrobe - b_str); end
    vectors++;
    if (addr_err - b_aerr !== 0) begin miscompares++; $display("FAIL frame2_addr got %0d bad strobes want 0", addr_err - b_aerr); end
    read_addr = 11'd5;
  endtask

  task automatic test_gating;
    int b_str, b_busy, b_done, b_rise;
    bit ok;
    logic [47:0] got;
    trigger = 1'b0; read_external = 1'b0;
    tick(3);
    b_str = nstrobe; b_busy = nbusy;
    read_external = 1'b1;
    tick(100);
    vectors++;
    if (nstrobe - b_str !== 0) begin miscompares++; $display("FAIL gate_trigger_strobes got %0d want 0", nstrobe - b_str); end
    vectors++;
    if (nbusy - b_busy !== 0) begin miscompares++; $display("FAIL gate_trigger_busy got %0d want 0", nbusy - b_busy); end

    set_words(16'h1771, 16'h17A4, 16'h0019);
    trigger = 1'b1; read_external = 1'b0;
    tick(2);
    b_str = nstrobe; b_done = ndone; b_rise = nrise;
    read_external = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (nrise > b_rise) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL busy_edge_shift_timeout rises=%0d want 1", nrise - b_rise); end
    tick(5);
    read_external = 1'b0;
    tick(2);
    trigger = 1'b0;
    tick(3);
    trigger = 1'b1;
    read_external = 1'b1;  // rising edge while busy in SHIFT
    wait_done(b_done, 200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL busy_edge_timeout done=%0d want 1", ndone - b_done); end
    tick(30);
    got = rx[NB-1 -: 48];
    vectors++;
    if (got !== 48'h1771_17A4_0019) begin miscompares++; $display("FAIL busy_edge_data got %h want 177117a40019", got); end
    vectors++;
    if (ndone - b_done !== 1) begin miscompares++; $display("FAIL busy_edge_done got %0d want 1", ndone - b_done); end
    vectors++;
    if (nstrobe - b_str !== 3) begin miscompares++; $display("FAIL busy_edge_strobes got %0d want 3", nstrobe - b_str); end
  endtask

  task automatic test_reset_mid_frame;
    int b_bits, b_done, b_str, b_busy;
    bit ok;
    read_external = 1'b0;
    tick(2);
    b_bits = nbits; b_done = ndone;
    read_external = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (nbits - b_bits >= 20) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL midrst_reach_bit20 got %0d bits want 20", nbits - b_bits); end
    rst = 1'b1;
    tick(1);
    vectors++;
    if ({rd_en, so, sv, busy, done} !== 5'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs got %b want 00000", {rd_en, so, sv, busy, done});
    end
    rst = 1'b0;
    b_str = nstrobe; b_busy = nbusy;
    tick(30);
    vectors++;
    if (nstrobe - b_str !== 0) begin miscompares++; $display("FAIL midrst_restart_strobes got %0d want 0", nstrobe - b_str); end
    vectors++;
    if (nbusy - b_busy !== 0) begin miscompares++; $display("FAIL midrst_restart_busy got %0d want 0", nbusy - b_busy); end
    vectors++;
    if (ndone - b_done !== 0) begin miscompares++; $display("FAIL midrst_done got %0d want 0", ndone - b_done); end
  endtask

  task automatic test_latency_sweep;
    int b_bits, b_done, edge_c;
    bit ok;
    logic [47:0] got;
    set_words(16'h1771, 16'h17A4, 16'h0019);
    trigger = 1'b1; read_addr = 11'd5; exp_addr = 11'd5;
    ext3 = 1'b0;
    tick(2);
    b_bits = nbits3; b_done = ndone3;
    @(negedge clk);
    ext3 = 1'b1;
    edge_c = cyc + 1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (ndone3 > b_done) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL lat3_timeout done=%0d want 1", ndone3 - b_done); end
    tick(2);
    got = rx3[NB-1 -: 48];
    vectors++;
    if (rise3_cyc - edge_c !== 6) begin miscompares++; $display("FAIL lat3_latency got %0d want 6", rise3_cyc - edge_c); end
    vectors++;
    if (got !== 48'h1771_17A4_0019) begin miscompares++; $display("FAIL lat3_data got %h want 177117a40019", got); end
    vectors++;
    if (nbits3 - b_bits !== NB) begin miscompares++; $display("FAIL lat3_bits got %0d want %0d", nbits3 - b_bits, NB); end
    vectors++;
    if (addr_err3 !== 0) begin miscompares++; $display("FAIL lat3_addr got %0d bad strobes want 0", addr_err3); end
  endtask

  initial begin
    set_words(16'h0000, 16'h0000, 16'h0000);
    test_reset;
    test_frame_content;
    test_second_frame;
    test_gating;
    test_reset_mid_frame;
    test_latency_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
